// File: rtl/peripheral_noc_pkg.sv
// Shared NoC constants: default link sizes and the default buffered-entry layout.
package peripheral_noc_pkg;

  localparam int unsigned FLIT_WIDTH_DEF = 32;
  localparam int unsigned CHANNELS_DEF   = 7;

  typedef struct packed {
    logic                      last;
    logic [FLIT_WIDTH_DEF-1:0] flit;
  } flit_entry_t;

endpackage

// File: rtl/peripheral_noc_vchannel_demux_if.sv
// Virtual-channel link bundle: shared flit/last with per-channel valid/ready in,
// per-channel flit/last/valid/ready out.
interface peripheral_noc_vchannel_demux_if
  import peripheral_noc_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH = FLIT_WIDTH_DEF,
  parameter int unsigned CHANNELS   = CHANNELS_DEF
);

  logic [FLIT_WIDTH-1:0]                in_flit;
  logic                                 in_last;
  logic [CHANNELS-1:0]                  in_valid;
  logic [CHANNELS-1:0]                  in_ready;
  logic [CHANNELS-1:0][FLIT_WIDTH-1:0]  out_flit;
  logic [CHANNELS-1:0]                  out_last;
  logic [CHANNELS-1:0]                  out_valid;
  logic [CHANNELS-1:0]                  out_ready;

  modport slave (
    input  in_flit, in_last, in_valid, out_ready,
    output in_ready, out_flit, out_last, out_valid
  );

  modport master (
    output in_flit, in_last, in_valid, out_ready,
    input  in_ready, out_flit, out_last, out_valid
  );

endinterface

// File: rtl/peripheral_noc_vchannel_fifo.sv
// Single-channel flit FIFO with count-based full/empty; ready depends on state only.
module peripheral_noc_vchannel_fifo #(
  parameter int unsigned FLIT_WIDTH   = 32,
  parameter int unsigned BUFFER_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [FLIT_WIDTH-1:0] i_flit,
  input  logic                  i_last,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic [FLIT_WIDTH-1:0] o_flit,
  output logic                  o_last
);

  localparam int unsigned PtrW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(BUFFER_DEPTH + 1);

  typedef struct packed {
    logic                  last;
    logic [FLIT_WIDTH-1:0] flit;
  } entry_t;

  entry_t          r_mem [BUFFER_DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic            w_push;
  logic            w_pop;
  entry_t          w_head;

  assign o_wr_ready = (r_count != CntW'(BUFFER_DEPTH));
  assign o_rd_valid = (r_count != '0);
  assign w_push     = i_wr_valid & o_wr_ready;
  assign w_pop      = o_rd_valid & i_rd_ready;
  assign w_head     = r_mem[r_rd_ptr];
  assign o_flit     = w_head.flit;
  assign o_last     = w_head.last;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(BUFFER_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Storage is not reset; entries are only observed once written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{last: i_last, flit: i_flit};
  end

endmodule

// File: rtl/peripheral_noc_vchannel_demux.sv
// Virtual-channel receive demux: steers shared link flits into per-channel FIFOs.
// Optional multi-valid checker enabled by PERIPHERAL_NOC_VCHANNEL_DEMUX_CHECK_EN.
module peripheral_noc_vchannel_demux
  import peripheral_noc_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH   = FLIT_WIDTH_DEF,
  parameter int unsigned CHANNELS     = CHANNELS_DEF,
  parameter int unsigned BUFFER_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
`ifdef PERIPHERAL_NOC_VCHANNEL_DEMUX_CHECK_EN
  output logic                            err_multi,
`endif
  peripheral_noc_vchannel_demux_if.slave  bus
);

  logic [CHANNELS-1:0]                 w_wr_valid;
  logic [CHANNELS-1:0]                 w_in_ready;
  logic [CHANNELS-1:0][FLIT_WIDTH-1:0] w_out_flit;
  logic [CHANNELS-1:0]                 w_out_last;
  logic [CHANNELS-1:0]                 w_out_valid;

`ifdef PERIPHERAL_NOC_VCHANNEL_DEMUX_CHECK_EN
  logic w_multi;
  logic r_err_multi;

  // Clearing the lowest set bit leaves a nonzero value iff two or more bits are set.
  assign w_multi    = ((bus.in_valid & (bus.in_valid - 1'b1)) != '0);
  assign w_wr_valid = w_multi ? '0 : bus.in_valid;
  assign err_multi  = r_err_multi;

  always_ff @(posedge clk) begin
    if (rst)          r_err_multi <= 1'b0;
    else if (w_multi) r_err_multi <= 1'b1;
  end
`else
  assign w_wr_valid = bus.in_valid;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    peripheral_noc_vchannel_fifo #(
      .FLIT_WIDTH   (FLIT_WIDTH),
      .BUFFER_DEPTH (BUFFER_DEPTH)
    ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_wr_valid (w_wr_valid[g]),
      .o_wr_ready (w_in_ready[g]),
      .i_flit     (bus.in_flit),
      .i_last     (bus.in_last),
      .o_rd_valid (w_out_valid[g]),
      .i_rd_ready (bus.out_ready[g]),
      .o_flit     (w_out_flit[g]),
      .o_last     (w_out_last[g])
    );
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_flit  = w_out_flit;
  assign bus.out_last  = w_out_last;
  assign bus.out_valid = w_out_valid;

endmodule

// File: tb/tb_peripheral_noc_vchannel_demux.sv
// Directed bench for peripheral_noc_vchannel_demux: vector table plus corner-case sequences.
module tb_peripheral_noc_vchannel_demux;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef PERIPHERAL_NOC_VCHANNEL_DEMUX_CHECK_EN
  logic err_multi;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  peripheral_noc_vchannel_demux_if #(.FLIT_WIDTH(32), .CHANNELS(7)) bus ();

  peripheral_noc_vchannel_demux #(
    .FLIT_WIDTH   (32),
    .CHANNELS     (7),
    .BUFFER_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef PERIPHERAL_NOC_VCHANNEL_DEMUX_CHECK_EN
    .err_multi (err_multi),
`endif
    .bus       (bus)
  );

  typedef struct {
    logic [6:0]  iv;
    logic [31:0] flit;
    logic        last;
    logic [6:0]  ordy;
    logic [6:0]  exp_ir;
    logic [6:0]  exp_ov;
    int          ch;      // -1: no head check
    logic [31:0] exp_flit;
    logic        exp_last;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] iv, input logic [31:0] f, input logic l,
                       input logic [6:0] ordy);
    bus.in_valid  = iv;
    bus.in_flit   = f;
    bus.in_last   = l;
    bus.out_ready = ordy;
  endtask

  initial begin
    int rx;
    drive(7'h00, 32'h0, 1'b0, 7'h00);

    // {iv, flit, last, ordy, exp in_ready, exp out_valid, head ch, head flit, head last}
    vecs[0]  = '{7'h00, 32'h0,         1'b0, 7'h00, 7'h7F, 7'h00, -1, 32'h0,         1'b0};
    vecs[1]  = '{7'h04, 32'hA5A5_0001, 1'b1, 7'h00, 7'h7F, 7'h00, -1, 32'h0,         1'b0};
    vecs[2]  = '{7'h00, 32'h0,         1'b0, 7'h04, 7'h7F, 7'h04,  2, 32'hA5A5_0001, 1'b1};
    vecs[3]  = '{7'h00, 32'h0,         1'b0, 7'h00, 7'h7F, 7'h00, -1, 32'h0,         1'b0};
    vecs[4]  = '{7'h01, 32'h10,        1'b0, 7'h00, 7'h7F, 7'h00, -1, 32'h0,         1'b0};
    vecs[5]  = '{7'h01, 32'h11,        1'b0, 7'h00, 7'h7F, 7'h01,  0, 32'h10,        1'b0};
    vecs[6]  = '{7'h01, 32'h12,        1'b0, 7'h00, 7'h7F, 7'h01,  0, 32'h10,        1'b0};
    vecs[7]  = '{7'h01, 32'h13,        1'b1, 7'h00, 7'h7F, 7'h01,  0, 32'h10,        1'b0};
    vecs[8]  = '{7'h01, 32'h14,        1'b0, 7'h00, 7'h7E, 7'h01,  0, 32'h10,        1'b0};
    vecs[9]  = '{7'h01, 32'h14,        1'b0, 7'h01, 7'h7E, 7'h01,  0, 32'h10,        1'b0};
    vecs[10] = '{7'h01, 32'h14,        1'b0, 7'h00, 7'h7F, 7'h01,  0, 32'h11,        1'b0};
    vecs[11] = '{7'h00, 32'h0,         1'b0, 7'h01, 7'h7E, 7'h01,  0, 32'h11,        1'b0};
    vecs[12] = '{7'h00, 32'h0,         1'b0, 7'h01, 7'h7F, 7'h01,  0, 32'h12,        1'b0};
    vecs[13] = '{7'h00, 32'h0,         1'b0, 7'h01, 7'h7F, 7'h01,  0, 32'h13,        1'b1};
    vecs[14] = '{7'h00, 32'h0,         1'b0, 7'h01, 7'h7F, 7'h01,  0, 32'h14,        1'b0};
    vecs[15] = '{7'h00, 32'h0,         1'b0, 7'h00, 7'h7F, 7'h00, -1, 32'h0,         1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_in_ready", 64'(bus.in_ready), 64'h7F);
    check("reset_out_valid", 64'(bus.out_valid), 64'h00);
`ifdef PERIPHERAL_NOC_VCHANNEL_DEMUX_CHECK_EN
    check("reset_err_multi", 64'(err_multi), 64'h0);
`endif

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].flit, vecs[i].last, vecs[i].ordy);
      #1;
      check($sformatf("vec%0d_in_ready", i), 64'(bus.in_ready), 64'(vecs[i].exp_ir));
      check($sformatf("vec%0d_out_valid", i), 64'(bus.out_valid), 64'(vecs[i].exp_ov));
      if (vecs[i].ch >= 0) begin
        check($sformatf("vec%0d_flit", i), 64'(bus.out_flit[vecs[i].ch]),
              64'(vecs[i].exp_flit));
        check($sformatf("vec%0d_last", i), 64'(bus.out_last[vecs[i].ch]),
              64'(vecs[i].exp_last));
      end
    end

    // Channel isolation: ch1 full and stalled while ch3/ch5 keep accepting.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(7'h02, 32'h100 + 32'(i), 1'b0, 7'h00);
      #1;
      check("iso_fill_ch1_ready", 64'(bus.in_ready[1]), 64'h1);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k % 2 == 0) drive(7'h08, 32'h30 + 32'(k / 2), 1'b0, 7'h00);
      else            drive(7'h20, 32'h50 + 32'(k / 2), 1'b0, 7'h00);
      #1;
      check("iso_ch1_blocked", 64'(bus.in_ready[1]), 64'h0);
      check("iso_ch3_ready", 64'(bus.in_ready[3]), 64'h1);
      check("iso_ch5_ready", 64'(bus.in_ready[5]), 64'h1);
    end
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      drive(7'h00, 32'h0, 1'b0, 7'h28);
      #1;
      check("iso_valid35", 64'(bus.out_valid & 7'h28), 64'h28);
      check("iso_ch3_order", 64'(bus.out_flit[3]), 64'h30 + 64'(j));
      check("iso_ch5_order", 64'(bus.out_flit[5]), 64'h50 + 64'(j));
    end
    @(negedge clk);
    drive(7'h00, 32'h0, 1'b0, 7'h00);
    #1;
    check("iso_after_drain_valid", 64'(bus.out_valid), 64'h02);
    check("iso_ch1_head", 64'(bus.out_flit[1]), 64'h100);
    check("iso_ch1_still_full", 64'(bus.in_ready), 64'h7D);

    // Reset mid-operation discards ch1 contents.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'h00);
    check("midrst_in_ready", 64'(bus.in_ready), 64'h7F);

    // Streaming through ch4 with continuous pop: order kept across pointer wraps.
    rx = 0;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      drive((k < 20) ? 7'h10 : 7'h00, 32'(k), 1'b0, 7'h10);
      #1;
      check("stream_in_ready", 64'(bus.in_ready[4]), 64'h1);
      if (bus.out_valid[4]) begin
        check("stream_order", 64'(bus.out_flit[4]), 64'(rx));
        rx++;
      end
    end
    check("stream_count", 64'(rx), 64'd20);
    @(negedge clk);
    drive(7'h00, 32'h0, 1'b0, 7'h00);
    #1;
    check("stream_empty", 64'(bus.out_valid), 64'h00);

    // Multiple valids in one cycle.
    @(negedge clk);
    drive(7'h09, 32'hDEAD_0009, 1'b1, 7'h00);
    @(negedge clk);
    drive(7'h00, 32'h0, 1'b0, 7'h00);
    #1;
`ifdef PERIPHERAL_NOC_VCHANNEL_DEMUX_CHECK_EN
    check("multi_no_write", 64'(bus.out_valid), 64'h00);
    check("multi_err_set", 64'(err_multi), 64'h1);
    repeat (3) @(negedge clk);
    #1;
    check("multi_err_sticky", 64'(err_multi), 64'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("multi_err_cleared", 64'(err_multi), 64'h0);
`else
    check("multi_both_written", 64'(bus.out_valid), 64'h09);
    check("multi_ch0_flit", 64'(bus.out_flit[0]), 64'hDEAD_0009);
    check("multi_ch3_flit", 64'(bus.out_flit[3]), 64'hDEAD_0009);
    check("multi_ch3_last", 64'(bus.out_last[3]), 64'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/peripheral_noc_vchannel_demux.md
Name: peripheral_noc_vchannel_demux

Overview:
- Receive side of a virtual-channel link: the physical link carries one shared flit/last bus with per-channel valid and ready.
- Each accepted flit is steered into a per-channel FIFO buffer, and each channel is presented on its own valid/ready output interface.
- Ready returned to the link is per channel and means "this channel has buffer space". One blocked channel never stalls the others.
- Sits at a router input port or a network-adapter ingress, facing the link-side channel multiplexer.

Parameters:
- FLIT_WIDTH, 32, width of flit payload.
- CHANNELS, 7, number of virtual channels; must be ≥1.
- BUFFER_DEPTH, 4, flits buffered per channel; must be ≥2, power of two not required.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- in_flit  input  FLIT_WIDTH  shared link flit
- in_last  input  1  shared link last-flit marker
- in_valid  input  CHANNELS  per-channel valid; one-hot or zero expected
- in_ready  output  CHANNELS  per-channel buffer-not-full
- out_flit  output  CHANNELS×FLIT_WIDTH  per-channel head flit (packed [CHANNELS-1:0][FLIT_WIDTH-1:0])
- out_last  output  CHANNELS  per-channel head last marker
- out_valid  output  CHANNELS  per-channel FIFO non-empty
- out_ready  input  CHANNELS  per-channel consumer ready

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values: every channel is empty, with rd_ptr=0, wr_ptr=0, count=0.
  - out_valid=0 and in_ready=all ones.
  - out_flit and out_last are don't-care while out_valid[c]=0.
- Write: channel c accepts {in_flit,in_last} on a rising edge when in_valid[c]&in_ready[c]. The entry is stored at wr_ptr[c], and wr_ptr[c] advances.
- Read: channel c pops on a rising edge when out_valid[c]&out_ready[c]. rd_ptr[c] advances.
- Pointer wrap: a pointer at BUFFER_DEPTH-1 wraps to 0 on advance.
- count[c] width is $clog2(BUFFER_DEPTH+1). On each edge count[c] changes as follows:
  - write only: +1
  - read only: -1
  - both: unchanged
  - neither: unchanged
- in_ready[c] = (count[c] != BUFFER_DEPTH).
  - It is a function of registered state only; there is no combinational path from out_ready to in_ready.
  - A full channel therefore refuses a write even in a cycle where it is also popped.
- out_valid[c] = (count[c] != 0). out_flit[c] and out_last[c] are read combinationally from the entry at rd_ptr[c].
- Latency: a flit written at edge N is visible on out_valid/out_flit after edge N, i.e. in cycle N+1. There is no write-to-read bypass.
- Empty boundary: a simultaneous write and read cannot occur on an empty channel (out_valid=0), so count goes 0→1.
- Full boundary: with count=BUFFER_DEPTH and out_ready=1, count goes to BUFFER_DEPTH-1. in_ready rises in the following cycle.
- Ordering: per-channel FIFO order is preserved. in_last is stored and forwarded unchanged; the block does no packet tracking.
- Multiple in_valid bits in one cycle (protocol violation, macro absent): every asserted channel with in_ready=1 writes the same flit. This behaviour is deterministic.
- Reset mid-operation: all buffered flits are discarded and every channel returns to the reset state on the next edge.

Optional Feature:
- Macro: PERIPHERAL_NOC_VCHANNEL_DEMUX_CHECK_EN.
- With the macro, an extra output port err_multi (1 bit) is present:
  - A cycle with more than one bit of in_valid set writes no channel.
  - err_multi is set on the following edge and stays set (sticky) until rst.
  - Reset value of err_multi is 0.
- Without the macro, the port and checker are absent, and multi-valid cycles behave as described under Behaviour.

Decomposition:
- Shared package peripheral_noc_pkg holds:
  - the default FLIT_WIDTH/CHANNELS constants;
  - a packed typedef for the buffered entry {last, flit}.
- Sub-module peripheral_noc_vchannel_fifo: one single-channel FIFO with count-based full/empty, instantiated CHANNELS times with a generate loop.
- The top level does valid fan-out and, optionally, the multi-valid check.

Test Plan:
- Reset then idle: assert rst 2 cycles → in_ready=7'h7F, out_valid=0, and this holds with in_valid=0.
- Single flit: ch2 gets in_flit=32'hA5A5_0001, in_last=1, for 1 cycle → next cycle out_valid=7'h04, out_flit[2]=A5A5_0001, out_last[2]=1. Pop with out_ready[2] → out_valid=0.
- Fill and backpressure: ch0, depth 4, out_ready=0, write 0x10..0x13 → in_ready[0]=0 after 4th accept.
  - A 5th flit (0x14) held valid is not accepted.
  - Raise out_ready[0] for 1 cycle → 0x10 pops. in_ready[0]=1 the next cycle, then 0x14 is accepted.
  - Drain order must be 0x11,0x12,0x13,0x14.
- Channel isolation: ch1 full and stalled; interleave writes to ch3 and ch5 → ch3 and ch5 accept every cycle and drain in order. in_ready[1] stays 0.
- Wrap and concurrent read/write: ch4 streams 20 flits (0..19) with out_ready=1 continuously → count never exceeds 1 and data arrives in order across multiple pointer wraps.
- Check enabled: in_valid=7'h09 for 1 cycle → no channel's count changes and err_multi=1 from the next cycle. err_multi stays 1 until rst, then reads 0.
